// File: rtl/pc_sequencer.sv
// pc_sequencer: run-control and return-address stack for a program counter.
// Decodes one instruction class per cycle and drives the counter's control
// inputs combinationally so the counter acts on the same edge this block
// updates its own state.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   START       IDLE->RUN; HALT/FAULT->IDLE
//   STALL       hold the current instruction address (RUN only)
//   INSTR_TYPE  0 SEQ, 1 JMP, 2 CALL, 3 RET, 4 HALT, 5-7 as SEQ
//   TARGET      jump/call destination
//   PC_ADDR     current instruction address from the counter
//   OP_CODE     to counter: 0 clear, 1 load JMP_ADDR, 2 load RET_ADDR, 3 increment
//   JMP_ADDR    to counter jump input
//   RET_ADDR    to counter return input (top of stack, 0 when empty)
//   STATE       0 IDLE, 1 RUN, 2 HALT, 3 FAULT
//   SP          stack occupancy, 0..STACK_DEPTH
//   FAULT       high while in FAULT
module pc_sequencer #(
   parameter int unsigned INSTR_ADDR_SIZE = 5,
   parameter int unsigned STACK_DEPTH     = 4
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               START,
   input  logic                               STALL,
   input  logic [2:0]                         INSTR_TYPE,
   input  logic [INSTR_ADDR_SIZE-1:0]         TARGET,
   input  logic [INSTR_ADDR_SIZE-1:0]         PC_ADDR,
   output logic [1:0]                         OP_CODE,
   output logic [INSTR_ADDR_SIZE-1:0]         JMP_ADDR,
   output logic [INSTR_ADDR_SIZE-1:0]         RET_ADDR,
   output logic [1:0]                         STATE,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   SP,
   output logic                               FAULT
);

   localparam int unsigned AW     = INSTR_ADDR_SIZE;
   localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SLOTS  = 2 ** IDX_W;

   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [1:0] OP_CLR  = 2'd0;
   localparam logic [1:0] OP_JMP  = 2'd1;
   localparam logic [1:0] OP_RET  = 2'd2;
   localparam logic [1:0] OP_INC  = 2'd3;

   localparam logic [2:0] I_JMP   = 3'd1;
   localparam logic [2:0] I_CALL  = 3'd2;
   localparam logic [2:0] I_RET   = 3'd3;
   localparam logic [2:0] I_HALT  = 3'd4;

   logic [1:0]      state_q, state_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            push;
   logic [AW-1:0]   stack [0:SLOTS-1];

   // State and stack pointer registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
      end
   end

   // Stack storage; contents are meaningless whenever SP says the slot is empty
   always_ff @(posedge CLK) begin
      if (push) begin
         stack[IDX_W'(sp_q)] <= PC_ADDR + AW'(1);
      end
   end

   // Next state, stack control and counter command
   always_comb begin
      state_d  = state_q;
      sp_d     = sp_q;
      push     = 1'b0;
      OP_CODE  = OP_JMP;
      JMP_ADDR = PC_ADDR;

      case (state_q)
         S_IDLE: begin
            OP_CODE = OP_CLR;
            if (START) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // Stall beats everything; the counter has no hold code so jump to self
            if (!STALL) begin
               case (INSTR_TYPE)
                  I_JMP: begin
                     JMP_ADDR = TARGET;
                  end
                  I_CALL: begin
                     if (sp_q < SP_FULL) begin
                        JMP_ADDR = TARGET;
                        push     = 1'b1;
                        sp_d     = sp_q + SP_ONE;
                     end else begin
                        state_d = S_FAULT;
                     end
                  end
                  I_RET: begin
                     if (sp_q != '0) begin
                        OP_CODE = OP_RET;
                        sp_d    = sp_q - SP_ONE;
                     end else begin
                        state_d = S_FAULT;
                     end
                  end
                  I_HALT: begin
                     state_d = S_HALT;
                  end
                  default: begin
                     OP_CODE = OP_INC;
                  end
               endcase
            end
         end

         default: begin
            // HALT and FAULT both hold until START returns to IDLE with an empty stack
            if (START) begin
               state_d = S_IDLE;
               sp_d    = '0;
            end
         end
      endcase
   end

   // Top of stack, zero when empty
   always_comb begin
      RET_ADDR = '0;
      if (sp_q != '0) begin
         RET_ADDR = stack[IDX_W'(sp_q - SP_ONE)];
      end
   end

   assign STATE = state_q;
   assign SP    = sp_q;
   assign FAULT = (state_q == S_FAULT);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the program counter's OP_CODE, JMP_ADDR and RET_ADDR inputs each cycle.
- Decodes a per-cycle instruction class (sequential, jump, call, return, halt).
- Owns a hardware return-address stack and a run-control state machine (idle/run/halt/fault).
- Handles stalls by issuing jump-to-self, because the counter has no hold code.

Parameters:
INSTR_ADDR_SIZE, 5, width of instruction addresses (matches counter).
STACK_DEPTH, 4, number of return-address stack entries (>=1).

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RST  input  1  asynchronous active-high reset.
START  input  1  run control: IDLE->RUN; HALT/FAULT->IDLE.
STALL  input  1  hold current instruction address this cycle (RUN only).
INSTR_TYPE  input  3  0 SEQ, 1 JMP, 2 CALL, 3 RET, 4 HALT; 5-7 treated as SEQ.
TARGET  input  INSTR_ADDR_SIZE  jump/call destination.
PC_ADDR  input  INSTR_ADDR_SIZE  current instruction address fed back from counter.
OP_CODE  output  2  to counter: 0 clear, 1 load JMP_ADDR, 2 load RET_ADDR, 3 increment.
JMP_ADDR  output  INSTR_ADDR_SIZE  to counter jump input.
RET_ADDR  output  INSTR_ADDR_SIZE  to counter return input.
STATE  output  2  0 IDLE, 1 RUN, 2 HALT, 3 FAULT.
SP  output  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH.
FAULT  output  1  high while in FAULT.

Behaviour:
- Registered state: STATE, SP, stack array. OP_CODE/JMP_ADDR/RET_ADDR are combinational (Mealy) from registered state and current inputs, so the counter acts on the same edge the sequencer updates (zero added latency).
- RST asserted (async): STATE=IDLE, SP=0, FAULT=0, stack contents don't-care. Outputs during reset follow IDLE: OP_CODE=0.
- "Hold" means OP_CODE=1 and JMP_ADDR=PC_ADDR.
- JMP_ADDR=TARGET only when issuing a JMP or CALL; otherwise JMP_ADDR=PC_ADDR.
- RET_ADDR = stack[SP-1] when SP>0, else 0.
- IDLE:
  - OP_CODE=0 every cycle.
  - START -> RUN next edge; first RUN cycle sees PC_ADDR=0.
- RUN, priority STALL > INSTR_TYPE:
  - STALL=1: hold; no stack or state change.
  - SEQ: OP_CODE=3. Counter wraps 2^N-1 -> 0, which is legal, not a fault.
  - JMP: OP_CODE=1, JMP_ADDR=TARGET.
  - CALL, SP<STACK_DEPTH: OP_CODE=1, JMP_ADDR=TARGET; push (PC_ADDR+1) mod 2^INSTR_ADDR_SIZE; SP+1.
  - CALL, SP==STACK_DEPTH (overflow): hold; no push; ->FAULT.
  - RET, SP>0: OP_CODE=2, RET_ADDR=top; SP-1.
  - RET, SP==0 (underflow): hold; ->FAULT.
  - HALT: hold; ->HALT.
  - START ignored in RUN.
- HALT:
  - Hold every cycle; SP and stack preserved.
  - START -> IDLE (SP cleared).
- FAULT:
  - Hold every cycle; FAULT=1; counter stays on the faulting instruction.
  - START -> IDLE (SP=0, FAULT=0).
- Inputs STALL/INSTR_TYPE/TARGET are ignored outside RUN.
- RST mid-CALL/RET: the async clear wins and the stack is discarded; counter receives OP_CODE=0 while RST is high.
- SP never exceeds STACK_DEPTH and never underflows; no simultaneous push+pop exists (one instruction per cycle).

Test Plan:
- Reset/start: RST pulse, START=1 one cycle, then 4 cycles SEQ -> OP_CODE=0 in IDLE; counter sequence 0,1,2,3,4; STATE=1.
- Call/return: at PC=3, CALL TARGET=20 -> OP_CODE=1, JMP_ADDR=20, SP=1, stack[0]=4. At PC=20, RET -> OP_CODE=2, RET_ADDR=4, SP=0, counter=4.
- Nested overflow (STACK_DEPTH=4): five consecutive CALLs -> first four push, SP=4. Fifth: OP_CODE=1 with JMP_ADDR=PC_ADDR, STATE=3, FAULT=1, SP stays 4. Then START -> STATE=0, SP=0, FAULT=0.
- Underflow and wrap: RET with SP=0 -> hold, FAULT=1. Separately, CALL at PC=31 (N=5) pushes 0; later RET returns counter to 0.
- Stall priority: STALL=1 together with CALL TARGET=9 for 3 cycles -> OP_CODE=1, JMP_ADDR=PC_ADDR, SP unchanged. On STALL=0 the CALL executes once and SP+1.
- Halt and async reset: HALT at PC=7 -> counter stays 7 over 10 cycles, STATE=2. Then RST asserted mid-cycle -> STATE=0 and OP_CODE=0 immediately (before the next edge); SP=0.
